// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: board-side responder for the PC command protocol.
// Receives 4-byte request frames (SYNC, CMD, ADDR, CHK) from the UART receiver,
// optionally reads a 32-bit register, and returns a checksummed response frame
// (RESP, STATUS, [D3 D2 D1 D0], RCHK) through the UART transmitter handshake.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   rx_data, rx_ready     received byte and its one-cycle valid pulse
//   tx_data, tx_start     byte to send and its one-cycle request pulse
//   tx_busy               transmitter busy flag
//   rd_en, rd_addr        register read strobe and index
//   rd_data               register value, valid the cycle after rd_en
//   state_leds            IDLE=0001, RX=0010, FETCH=0100, TX=1000
//   err_cnt               saturating count of bad frames and timeouts
module uart_cmd_responder #(
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter logic [7:0]  RESP_BYTE   = 8'h5A,
    parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        rd_en,
    output logic [3:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic [3:0]  state_leds,
    output logic [7:0]  err_cnt
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    localparam logic [7:0] CMD_READ = 8'h01;
    localparam logic [7:0] CMD_PING = 8'h02;
    localparam logic [7:0] ST_OK    = 8'h00;
    localparam logic [7:0] ST_CHK   = 8'hE1;
    localparam logic [7:0] ST_CMD   = 8'hE2;

    localparam logic [3:0] LED_IDLE  = 4'b0001;
    localparam logic [3:0] LED_RX    = 4'b0010;
    localparam logic [3:0] LED_FETCH = 4'b0100;
    localparam logic [3:0] LED_TX    = 4'b1000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_GET_CMD,
        S_GET_ADDR,
        S_GET_CHK,
        S_EVAL,
        S_FETCH_REQ,
        S_FETCH_CAP,
        S_SEND,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t           state;
    logic [7:0]       cmd;
    logic [7:0]       addr;
    logic [7:0]       chk;
    logic [TMO_W-1:0] tmo_cnt;
    logic [55:0]      tx_shift;   // response bytes, next byte in the top octet
    logic [2:0]       byte_cnt;   // response bytes still to be started

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Frame receive, evaluate, fetch and transmit sequencing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            state_leds <= LED_IDLE;
            tx_data    <= 8'h00;
            tx_start   <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= 4'h0;
            err_cnt    <= 8'h00;
            cmd        <= 8'h00;
            addr       <= 8'h00;
            chk        <= 8'h00;
            tmo_cnt    <= '0;
            tx_shift   <= 56'h0;
            byte_cnt   <= 3'd0;
        end else begin
            tx_start <= 1'b0;
            rd_en    <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (rx_ready && (rx_data == SYNC_BYTE)) begin
                        state      <= S_GET_CMD;
                        state_leds <= LED_RX;
                        tmo_cnt    <= '0;
                    end
                end

                // A received byte always beats a coincident timeout.
                S_GET_CMD, S_GET_ADDR, S_GET_CHK: begin
                    if (rx_ready) begin
                        tmo_cnt <= '0;
                        if (state == S_GET_CMD) begin
                            cmd   <= rx_data;
                            state <= S_GET_ADDR;
                        end else if (state == S_GET_ADDR) begin
                            addr  <= rx_data;
                            state <= S_GET_CHK;
                        end else begin
                            chk   <= rx_data;
                            state <= S_EVAL;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state      <= S_IDLE;
                        state_leds <= LED_IDLE;
                        err_cnt    <= sat_inc(err_cnt);
                        tmo_cnt    <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                // Checksum is judged before the command code.
                S_EVAL: begin
                    if (chk != (cmd ^ addr)) begin
                        tx_shift   <= {RESP_BYTE, ST_CHK, ST_CHK, 32'h0};
                        byte_cnt   <= 3'd3;
                        err_cnt    <= sat_inc(err_cnt);
                        state      <= S_SEND;
                        state_leds <= LED_TX;
                    end else if (cmd == CMD_READ) begin
                        rd_en      <= 1'b1;
                        rd_addr    <= addr[3:0];
                        state      <= S_FETCH_REQ;
                        state_leds <= LED_FETCH;
                    end else if (cmd == CMD_PING) begin
                        tx_shift   <= {RESP_BYTE, ST_OK, ST_OK, 32'h0};
                        byte_cnt   <= 3'd3;
                        state      <= S_SEND;
                        state_leds <= LED_TX;
                    end else begin
                        tx_shift   <= {RESP_BYTE, ST_CMD, ST_CMD, 32'h0};
                        byte_cnt   <= 3'd3;
                        err_cnt    <= sat_inc(err_cnt);
                        state      <= S_SEND;
                        state_leds <= LED_TX;
                    end
                end

                // rd_en is high during this cycle; data arrives next cycle.
                S_FETCH_REQ: begin
                    state <= S_FETCH_CAP;
                end

                S_FETCH_CAP: begin
                    tx_shift   <= {RESP_BYTE, ST_OK, rd_data,
                                   ST_OK ^ rd_data[31:24] ^ rd_data[23:16]
                                         ^ rd_data[15:8]  ^ rd_data[7:0]};
                    byte_cnt   <= 3'd7;
                    state      <= S_SEND;
                    state_leds <= LED_TX;
                end

                S_SEND: begin
                    if (!tx_busy) begin
                        tx_data  <= tx_shift[55:48];
                        tx_shift <= {tx_shift[47:0], 8'h00};
                        byte_cnt <= byte_cnt - 3'd1;
                        tx_start <= 1'b1;
                        state    <= S_WAIT_HI;
                    end
                end

                S_WAIT_HI: begin
                    if (tx_busy) begin
                        state <= S_WAIT_LO;
                    end
                end

                S_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (byte_cnt == 3'd0) begin
                            state      <= S_IDLE;
                            state_leds <= LED_IDLE;
                        end else begin
                            state <= S_SEND;
                        end
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    state_leds <= LED_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed testbench for uart_cmd_responder with a transmitter busy model,
// a register-port model and a monitor that logs every started tx byte.
module tb_uart_cmd_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic [3:0]  state_leds;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    // Monitor state, written only by the monitor process.
    logic [7:0] tx_q[$];
    int         lat_q[$];
    int         cyc = 0;
    int         last_rx = 0;
    int         rd_cnt = 0;
    int         bad_start = 0;

    // Transmitter model.
    int busy_len = 4;
    int busy_cnt = 0;

    uart_cmd_responder #(
        .SYNC_BYTE  (8'hA5),
        .RESP_BYTE  (8'h5A),
        .TIMEOUT_CYC(100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .state_leds(state_leds),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    assign tx_busy = (busy_cnt != 0);

    // Busy rises the cycle after tx_start and lasts busy_len cycles.
    always @(posedge clk) begin
        if (reset) busy_cnt <= 0;
        else if (tx_start && busy_cnt == 0) busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    // Register port: value presented the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) rd_data <= (rd_addr == 4'd3) ? 32'hDEADBEEF : {28'h0, rd_addr};
        else       rd_data <= 32'h0;
    end

    // Monitor: log starts, first-byte latency relative to the last rx byte, reads.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_ready) last_rx <= cyc;
        if (tx_start) begin
            tx_q.push_back(tx_data);
            lat_q.push_back(cyc - last_rx);
            if (tx_busy) bad_start <= bad_start + 1;
        end
        if (rd_en) rd_cnt <= rd_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        rx_ready = 1'b0;
        rx_data = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [31:0] f);
        send_byte(f[31:24]);
        send_byte(f[23:16]);
        send_byte(f[15:8]);
        send_byte(f[7:0]);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!(state_leds == 4'b0001 && !tx_busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 64'(n < 5000), 64'd1);
    endtask

    task automatic expect_frame(input string tag, input int base, input int n,
                                input logic [55:0] exp);
        logic [63:0] got;
        check({tag, "_len"}, 64'(tx_q.size() - base), 64'(n));
        for (int i = 0; i < n; i++) begin
            got = (base + i < tx_q.size()) ? 64'(tx_q[base + i]) : 64'hFFFF;
            check($sformatf("%s_b%0d", tag, i), got, 64'(exp[55 - 8*i -: 8]));
        end
    endtask

    initial begin
        int base;
        int rd0;
        int n;
        reset    = 1'b1;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset values
        check("rst_tx_data", 64'(tx_data), 64'h0);
        check("rst_tx_start", 64'(tx_start), 64'h0);
        check("rst_rd_en", 64'(rd_en), 64'h0);
        check("rst_rd_addr", 64'(rd_addr), 64'h0);
        check("rst_err", 64'(err_cnt), 64'h0);
        check("rst_leds", 64'(state_leds), 64'h1);

        // Ping
        base = tx_q.size();
        send_frame(32'hA5020002);
        wait_done("ping");
        expect_frame("ping", base, 3, {8'h5A, 8'h00, 8'h00, 32'h0});
        check("ping_lat", 64'(lat_q[base]), 64'd3);
        check("ping_err", 64'(err_cnt), 64'd0);
        check("ping_leds", 64'(state_leds), 64'h1);

        // Read register 3
        base = tx_q.size();
        rd0 = rd_cnt;
        send_frame(32'hA5010302);
        wait_done("read");
        expect_frame("read", base, 7, {8'h5A, 8'h00, 32'hDEADBEEF, 8'h22});
        check("read_lat", 64'(lat_q[base]), 64'd5);
        check("read_rd_cnt", 64'(rd_cnt - rd0), 64'd1);
        check("read_rd_addr", 64'(rd_addr), 64'd3);

        // Bad checksum
        do_reset();
        base = tx_q.size();
        rd0 = rd_cnt;
        send_frame(32'hA50103FF);
        wait_done("badchk");
        expect_frame("badchk", base, 3, {8'h5A, 8'hE1, 8'hE1, 32'h0});
        check("badchk_lat", 64'(lat_q[base]), 64'd3);
        check("badchk_err", 64'(err_cnt), 64'd1);
        check("badchk_no_rd", 64'(rd_cnt - rd0), 64'd0);

        // Unknown command, then junk ahead of a ping
        do_reset();
        base = tx_q.size();
        send_frame(32'hA5070007);
        wait_done("badcmd");
        expect_frame("badcmd", base, 3, {8'h5A, 8'hE2, 8'hE2, 32'h0});
        check("badcmd_err", 64'(err_cnt), 64'd1);
        base = tx_q.size();
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        check("junk_leds", 64'(state_leds), 64'h1);
        send_frame(32'hA5020002);
        wait_done("junkping");
        expect_frame("junkping", base, 3, {8'h5A, 8'h00, 8'h00, 32'h0});
        check("junkping_err", 64'(err_cnt), 64'd1);

        // SYNC value as ADDR is data: reads register 5, no resync
        base = tx_q.size();
        send_frame(32'hA501A5A4);
        wait_done("syncdata");
        expect_frame("syncdata", base, 7, {8'h5A, 8'h00, 32'h00000005, 8'h05});
        check("syncdata_rd_addr", 64'(rd_addr), 64'd5);

        // Timeout after two bytes
        do_reset();
        base = tx_q.size();
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (50) @(negedge clk);
        check("tmo_early_leds", 64'(state_leds), 64'h2);
        repeat (100) @(negedge clk);
        check("tmo_leds", 64'(state_leds), 64'h1);
        check("tmo_err", 64'(err_cnt), 64'd1);
        check("tmo_no_tx", 64'(tx_q.size() - base), 64'd0);
        base = tx_q.size();
        send_frame(32'hA5020002);
        wait_done("tmoping");
        expect_frame("tmoping", base, 3, {8'h5A, 8'h00, 8'h00, 32'h0});

        // Slow transmitter
        busy_len = 200;
        base = tx_q.size();
        send_frame(32'hA5010302);
        wait_done("slow");
        expect_frame("slow", base, 7, {8'h5A, 8'h00, 32'hDEADBEEF, 8'h22});
        check("slow_start_while_busy", 64'(bad_start), 64'd0);

        // Reset during byte 3 of a read response
        busy_len = 20;
        base = tx_q.size();
        send_frame(32'hA5010302);
        n = 0;
        while (tx_q.size() < base + 3 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rstmid_reach_b3", 64'(n < 2000), 64'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rstmid_tx_data", 64'(tx_data), 64'h0);
        check("rstmid_tx_start", 64'(tx_start), 64'h0);
        check("rstmid_rd_en", 64'(rd_en), 64'h0);
        check("rstmid_rd_addr", 64'(rd_addr), 64'h0);
        check("rstmid_err", 64'(err_cnt), 64'h0);
        check("rstmid_leds", 64'(state_leds), 64'h1);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("rstmid_no_more_tx", 64'(tx_q.size() - base), 64'd3);

        // err_cnt saturation
        busy_len = 1;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send_frame(32'hA50103FF);
            wait_done("sat");
        end
        check("sat_err", 64'(err_cnt), 64'd255);
        check("final_start_while_busy", 64'(bad_start), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
